// File: rtl/autoconfig_master.sv
// ---------------------------------------------------------------------------
// autoconfig_master
//
// Purpose:
//   Zorro II style AutoConfig bus master. On START it reads the 20 identity
//   nibbles (word indices 0x00..0x13) of the board in configuration space
//   (A23..A16 = 0xE8) and assembles ER_TYPE, PRODUCT and MANUFACTURER.
//   A valid board (ER_TYPE[7:6] == 2'b11) is given its base address with two
//   nibble writes (index 0x25 low nibble, then 0x24 high nibble). Any other
//   board is shut up with a single write of 4'h0 to index 0x26.
//
// Optional feature macro:
//   AUTOCONFIG_TIMEOUT_EN - when defined, a bus cycle that sees no DTACK
//     within TIMEOUT_CYCLES clocks of WAIT is ended, NO_BOARD is set and the
//     sequence finishes. When undefined, WAIT holds until DTACK arrives.
//
// Ports:
//   i_mb_clk        motherboard clock, all state on its rising edge
//   i_reset         asynchronous active-high reset
//   i_start         one-clock request for a configuration sequence
//   i_base_address  base to assign (A23..A16), sampled on the accepted start
//   i_mb_dtack      active-low bus acknowledge
//   i_data_in       responder nibble on D15..D12
//   o_mb_as         active-low address strobe
//   o_rw            1 = read, 0 = write
//   o_uds / o_lds   active-low data strobes (LDS never asserted)
//   o_address_high  0xE8 during a bus cycle, 0x00 otherwise
//   o_address_low   word index of the current AutoConfig register
//   o_data_out      write nibble, o_data_oe its output enable
//   o_busy, o_done, o_no_board, o_invalid   sequence status
//   o_er_type, o_product, o_manufacturer    decoded board identity
// ---------------------------------------------------------------------------
module autoconfig_master #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        i_mb_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [7:0]  i_base_address,
  input  logic        i_mb_dtack,
  input  logic [3:0]  i_data_in,
  output logic        o_mb_as,
  output logic        o_rw,
  output logic        o_uds,
  output logic        o_lds,
  output logic [7:0]  o_address_high,
  output logic [6:0]  o_address_low,
  output logic [3:0]  o_data_out,
  output logic        o_data_oe,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_no_board,
  output logic        o_invalid,
  output logic [7:0]  o_er_type,
  output logic [7:0]  o_product,
  output logic [15:0] o_manufacturer
);

  localparam logic [7:0] AC_SPACE       = 8'hE8;
  localparam logic [6:0] IDX_LAST_READ  = 7'h13;
  localparam logic [6:0] IDX_BASE_LO    = 7'h25;
  localparam logic [6:0] IDX_BASE_HI    = 7'h24;
  localparam logic [6:0] IDX_SHUTUP     = 7'h26;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("autoconfig_master: TIMEOUT_CYCLES must be in 1..255");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_STROBE,
    ST_WAIT,
    ST_LATCH,
    ST_RECOVER,
    ST_FINISH
  } state_t;

  state_t      r_state,  w_state;
  logic [6:0]  r_index,  w_index;
  logic        r_rw,     w_rw;
  logic        r_mb_as,  w_mb_as;
  logic        r_uds,    w_uds;
  logic        r_data_oe, w_data_oe;
  logic [7:0]  r_addr_high, w_addr_high;
  logic [3:0]  r_data_out, w_data_out;
  logic        r_busy,   w_busy;
  logic        r_done,   w_done;
  logic        r_no_board, w_no_board;
  logic        r_invalid, w_invalid;
  logic [7:0]  r_er_type, w_er_type;
  logic [7:0]  r_product, w_product;
  logic [15:0] r_manufacturer, w_manufacturer;
  logic [7:0]  r_base,   w_base;
  logic        w_to_finish;

`ifdef AUTOCONFIG_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0]  r_timer,  w_timer;
`endif

  // All bus outputs are registered from next-state values so that the
  // strobes are glitch-free and the asynchronous reset drives them straight
  // to their idle levels without passing through RECOVER.
  always_ff @(posedge i_mb_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= ST_IDLE;
      r_index        <= '0;
      r_rw           <= 1'b1;
      r_mb_as        <= 1'b1;
      r_uds          <= 1'b1;
      r_data_oe      <= 1'b0;
      r_addr_high    <= '0;
      r_data_out     <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_no_board     <= 1'b0;
      r_invalid      <= 1'b0;
      r_er_type      <= '0;
      r_product      <= '0;
      r_manufacturer <= '0;
      r_base         <= '0;
`ifdef AUTOCONFIG_TIMEOUT_EN
      r_timer        <= '0;
`endif
    end else begin
      r_state        <= w_state;
      r_index        <= w_index;
      r_rw           <= w_rw;
      r_mb_as        <= w_mb_as;
      r_uds          <= w_uds;
      r_data_oe      <= w_data_oe;
      r_addr_high    <= w_addr_high;
      r_data_out     <= w_data_out;
      r_busy         <= w_busy;
      r_done         <= w_done;
      r_no_board     <= w_no_board;
      r_invalid      <= w_invalid;
      r_er_type      <= w_er_type;
      r_product      <= w_product;
      r_manufacturer <= w_manufacturer;
      r_base         <= w_base;
`ifdef AUTOCONFIG_TIMEOUT_EN
      r_timer        <= w_timer;
`endif
    end
  end

  // Next-state and next-output logic. Each bus cycle is
  // ADDR -> STROBE -> WAIT (until DTACK) -> LATCH -> RECOVER, and RECOVER
  // decides which cycle follows: the next read, the base-address writes,
  // the shut-up write, or FINISH.
  always_comb begin
    w_state        = r_state;
    w_index        = r_index;
    w_rw           = r_rw;
    w_mb_as        = r_mb_as;
    w_uds          = r_uds;
    w_data_oe      = r_data_oe;
    w_addr_high    = r_addr_high;
    w_data_out     = r_data_out;
    w_busy         = r_busy;
    w_done         = r_done;
    w_no_board     = r_no_board;
    w_invalid      = r_invalid;
    w_er_type      = r_er_type;
    w_product      = r_product;
    w_manufacturer = r_manufacturer;
    w_base         = r_base;
    w_to_finish    = 1'b0;
`ifdef AUTOCONFIG_TIMEOUT_EN
    w_timer        = r_timer;
`endif

    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state     = ST_ADDR;
          w_index     = '0;
          w_rw        = 1'b1;
          w_addr_high = AC_SPACE;
          w_base      = i_base_address;
          w_busy      = 1'b1;
          w_done      = 1'b0;
          w_no_board  = 1'b0;
          w_invalid   = 1'b0;
        end
      end

      // Reads assert UDS together with AS; writes only drive the data bus
      // here and assert UDS one clock later.
      ST_ADDR: begin
        w_state   = ST_STROBE;
        w_mb_as   = 1'b0;
        w_uds     = ~r_rw;
        w_data_oe = ~r_rw;
      end

      // DTACK is deliberately ignored here so that a responder still holding
      // DTACK from an earlier cycle cannot shorten this one.
      ST_STROBE: begin
        w_state = ST_WAIT;
        w_uds   = 1'b0;
`ifdef AUTOCONFIG_TIMEOUT_EN
        w_timer = '0;
`endif
      end

      ST_WAIT: begin
        if (!i_mb_dtack) begin
          w_state = ST_LATCH;
        end
`ifdef AUTOCONFIG_TIMEOUT_EN
        else if (r_timer == TIMEOUT_LAST) begin
          w_state    = ST_RECOVER;
          w_mb_as    = 1'b1;
          w_uds      = 1'b1;
          w_no_board = 1'b1;
        end else begin
          w_timer = r_timer + 8'd1;
        end
`endif
      end

      // PRODUCT and MANUFACTURER are stored inverted on the board; ER_TYPE
      // nibbles are taken as read.
      ST_LATCH: begin
        w_state = ST_RECOVER;
        w_mb_as = 1'b1;
        w_uds   = 1'b1;
        if (r_rw) begin
          case (r_index)
            7'h00:   w_er_type[7:4]        = i_data_in;
            7'h01:   w_er_type[3:0]        = i_data_in;
            7'h02:   w_product[7:4]        = ~i_data_in;
            7'h03:   w_product[3:0]        = ~i_data_in;
            7'h08:   w_manufacturer[15:12] = ~i_data_in;
            7'h09:   w_manufacturer[11:8]  = ~i_data_in;
            7'h0A:   w_manufacturer[7:4]   = ~i_data_in;
            7'h0B:   w_manufacturer[3:0]   = ~i_data_in;
            default: ;
          endcase
        end
      end

      // DATA_OE stays asserted through RECOVER and is dropped as the next
      // cycle (or FINISH) begins.
      ST_RECOVER: begin
        if (r_no_board) begin
          w_to_finish = 1'b1;
        end else if (r_rw && (r_index != IDX_LAST_READ)) begin
          w_state   = ST_ADDR;
          w_index   = r_index + 7'd1;
          w_data_oe = 1'b0;
        end else if (r_rw) begin
          w_state   = ST_ADDR;
          w_rw      = 1'b0;
          w_data_oe = 1'b0;
          if (r_er_type[7:6] == 2'b11) begin
            w_index    = IDX_BASE_LO;
            w_data_out = r_base[3:0];
          end else begin
            w_invalid  = 1'b1;
            w_index    = IDX_SHUTUP;
            w_data_out = 4'h0;
          end
        end else if (r_index == IDX_BASE_LO) begin
          w_state    = ST_ADDR;
          w_index    = IDX_BASE_HI;
          w_data_out = r_base[7:4];
          w_data_oe  = 1'b0;
        end else begin
          w_to_finish = 1'b1;
        end
      end

      ST_FINISH: begin
        w_state = ST_IDLE;
      end

      default: begin
        w_state = ST_IDLE;
      end
    endcase

    // Common exit into FINISH: bus released, DONE latched until next start.
    if (w_to_finish) begin
      w_state     = ST_FINISH;
      w_rw        = 1'b1;
      w_data_oe   = 1'b0;
      w_addr_high = '0;
      w_busy      = 1'b0;
      w_done      = 1'b1;
    end
  end

  assign o_mb_as        = r_mb_as;
  assign o_rw           = r_rw;
  assign o_uds          = r_uds;
  assign o_lds          = 1'b1;
  assign o_address_high = r_addr_high;
  assign o_address_low  = r_index;
  assign o_data_out     = r_data_out;
  assign o_data_oe      = r_data_oe;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_no_board     = r_no_board;
  assign o_invalid      = r_invalid;
  assign o_er_type      = r_er_type;
  assign o_product      = r_product;
  assign o_manufacturer = r_manufacturer;

endmodule

// File: doc/autoconfig_master.md
AUTOCONFIG_MASTER -- requirements
Module: autoconfig_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, is the number of MB_CLK edges a bus cycle waits for DTACK before abort (8-bit range, 1..255).
REQ-002 MB_CLK  in  1  7 MHz motherboard clock; the only clock in the block, all state on its rising edge.
REQ-003 RESET  in  1  asynchronous, active-high reset.
REQ-004 START  in  1  one-clock request to run a full configuration sequence.
REQ-005 BASE_ADDRESS  in  8  base to assign (A23..A16), sampled on the accepted START.
REQ-006 MB_DTACK  in  1  active-low bus acknowledge from the responder.
REQ-007 DATA_IN  in  4  responder nibble on D15..D12.
REQ-008 MB_AS  out  1  active-low address strobe.
REQ-009 RW  out  1  1 = read, 0 = write.
REQ-010 UDS / LDS  out  1 each  active-low data strobes; LDS is held 1 at all times.
REQ-011 ADDRESS_HIGH  out  8  A23..A16; 8'hE8 during a bus cycle, 8'h00 otherwise.
REQ-012 ADDRESS_LOW  out  7  word index of the current AutoConfig register.
REQ-013 DATA_OUT / DATA_OE  out  4 / 1  write nibble and its output enable.
REQ-014 BUSY, DONE, NO_BOARD, INVALID  out  1 each  sequence status flags.
REQ-015 ER_TYPE / PRODUCT / MANUFACTURER  out  8 / 8 / 16  decoded board identity.

Function
REQ-016 FSM states: IDLE, ADDR, STROBE, WAIT, LATCH, RECOVER, FINISH; START is accepted only in IDLE and is ignored while BUSY=1.
REQ-017 Each bus cycle runs ADDR (1 clk: address and RW valid, MB_AS=1) -> STROBE (1 clk: MB_AS=0; UDS=0 on reads; DATA_OE=1 on writes) -> WAIT.
REQ-018 On writes, UDS goes low on entry to WAIT, one clock after MB_AS.
REQ-019 WAIT samples MB_DTACK on every edge; a sample of 0 moves the FSM to LATCH, and a DTACK already low during STROBE is not counted.
REQ-020 LATCH (1 clk) captures DATA_IN on reads; RECOVER (1 clk) sets MB_AS=UDS=1 with DATA_OE still 1; DATA_OE drops in the following ADDR or FINISH.
REQ-021 Minimum cycle length is 5 clocks; ADDRESS_LOW and RW stay stable from ADDR through RECOVER.
REQ-022 Read phase: indices 0x00..0x13 in ascending order (20 cycles).
REQ-023 Nibble assembly: ER_TYPE = {n00,n01} as read (not inverted); PRODUCT = ~{n02,n03}; MANUFACTURER = ~{n08,n09,n0A,n0B}.
REQ-024 Nibbles 0x04..0x07 and 0x0C..0x13 are read and discarded.
REQ-025 Valid board: ER_TYPE[7:6] == 2'b11.
REQ-026 Valid path: write 0x25 with BASE_ADDRESS[3:0], then write 0x24 with BASE_ADDRESS[7:4].
REQ-027 Invalid path: set INVALID=1 and write 0x26 with data 4'h0 (shutup).
REQ-028 FINISH: BUSY=0 and DONE=1 held until the next accepted START, which clears DONE, NO_BOARD and INVALID.
REQ-029 Identity outputs hold their last values until the next sequence overwrites them.

Reset
REQ-030 While RESET=1, asynchronously: state=IDLE; MB_AS=UDS=LDS=RW=1; DATA_OE=0; ADDRESS_HIGH=ADDRESS_LOW=DATA_OUT=0; BUSY=DONE=NO_BOARD=INVALID=0; ER_TYPE=PRODUCT=MANUFACTURER=0.
REQ-031 RESET asserted mid-cycle releases all strobes within the same clock period, with no RECOVER state; the aborted sequence is not resumed on release.
REQ-032 The first START is accepted on the first rising edge after RESET falls.

Configuration
REQ-033 Macro AUTOCONFIG_TIMEOUT_EN defined: a WAIT counter that reaches TIMEOUT_CYCLES ends the cycle via RECOVER, sets NO_BOARD=1, skips all remaining cycles and enters FINISH.
REQ-034 AUTOCONFIG_TIMEOUT_EN undefined: WAIT waits for DTACK indefinitely, NO_BOARD stays 0, and TIMEOUT_CYCLES is unused.

Verification
REQ-035 Responder model returns C,4,9,B,7,F,F,F,F,8,4,6,... with DTACK 2 clks after MB_AS; START with BASE_ADDRESS=8'h20 -> ER_TYPE=0xC4, PRODUCT=0x64, MANUFACTURER=0x07B9, write 0x25/data 0 then 0x24/data 2, DONE=1, INVALID=0.
REQ-036 Responder returns nibble 0x00 = 4'h4 -> INVALID=1, single write to 0x26, no 0x24/0x25 writes.
REQ-037 With AUTOCONFIG_TIMEOUT_EN and DTACK never asserted -> first cycle ends after 255 WAIT clocks, NO_BOARD=1, DONE=1, exactly one MB_AS assertion.
REQ-038 RESET pulsed during WAIT of read index 0x07 -> MB_AS/UDS high and DATA_OE=0 before the next clock edge, BUSY=0; a subsequent START restarts at index 0x00.
REQ-039 START re-pulsed while BUSY -> ignored, and the sequence contains exactly 22 bus cycles; DTACK held low throughout -> every cycle still takes exactly 5 clocks.
